// File: rtl/ntt_pkg.sv
// Shared NTT sizing constants and zeta-address helpers for the zeta ROM scheduler.
package ntt_pkg;

  localparam int NTT_STAGE_CNT = 8;
  localparam int ZETA_CYCLES   = 1 << (NTT_STAGE_CNT - 2);

  typedef logic [NTT_STAGE_CNT-2:0] zeta_addr_t;
  typedef logic [NTT_STAGE_CNT-3:0] zeta_cnt_t;

  // Stage 0 falls out as 0: the shift clears every bit and the mirror mask is 0.
  function automatic zeta_addr_t zeta_addr(input zeta_cnt_t cnt, input logic lane,
                                           input int stage, input logic inv);
    zeta_addr_t fwd;
    zeta_addr_t mask;
    fwd  = zeta_addr_t'({cnt, lane}) >> (NTT_STAGE_CNT - 1 - stage);
    mask = zeta_addr_t'((32'd1 << stage) - 32'd1);
    return inv ? (mask - fwd) : fwd;
  endfunction

endpackage

// File: rtl/ntt_zeta_sched_if.sv
// Control/ROM-side bus of the zeta scheduler; `inverse` exists only with ZETA_SCHED_INTT_EN.
interface ntt_zeta_sched_if;
  import ntt_pkg::*;

  logic start;
  logic ready;
`ifdef ZETA_SCHED_INTT_EN
  logic inverse;
`endif
  zeta_addr_t [1:0][NTT_STAGE_CNT-1:0] rom_addr;
  logic [NTT_STAGE_CNT-1:0]             stage_valid;
  logic                                 done;

`ifdef ZETA_SCHED_INTT_EN
  modport master (output start, output inverse, input ready, input rom_addr, input stage_valid, input done);
  modport slave  (input start, input inverse, output ready, output rom_addr, output stage_valid, output done);
`else
  modport master (output start, input ready, input rom_addr, input stage_valid, input done);
  modport slave  (input start, output ready, output rom_addr, output stage_valid, output done);
`endif

endinterface

// File: rtl/ntt_zeta_sched_stage_cnt.sv
// Per-stage butterfly counter: runs ZETA_CYCLES cycles per token and emits registered zeta addresses.
// Inverse-flag storage exists only with ZETA_SCHED_INTT_EN.
module zeta_stage_cnt
  import ntt_pkg::*;
#(
  parameter int STAGE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tok,
`ifdef ZETA_SCHED_INTT_EN
  input  logic       inv,
`endif
  output logic       valid,
  output zeta_addr_t addr0,
  output zeta_addr_t addr1,
  output logic       last,
  output logic       free
);

  localparam zeta_cnt_t CNT_LAST = zeta_cnt_t'(ZETA_CYCLES - 1);

  zeta_cnt_t cnt_r;
  zeta_cnt_t cnt_nxt_s;
  logic      act_nxt_s;
  logic      inv_nxt_s;

`ifdef ZETA_SCHED_INTT_EN
  logic inv_r;

  // direction flag is latched together with each token
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_r <= 1'b0;
    end else begin
      inv_r <= inv_nxt_s;
    end
  end

  assign inv_nxt_s = tok ? inv : inv_r;
`else
  assign inv_nxt_s = 1'b0;
`endif

  // a token restarts the count even on the last cycle, giving bubble-free back-to-back runs
  always_comb begin
    act_nxt_s = valid;
    cnt_nxt_s = cnt_r;
    if (tok) begin
      act_nxt_s = 1'b1;
      cnt_nxt_s = '0;
    end else if (valid) begin
      if (cnt_r == CNT_LAST) begin
        act_nxt_s = 1'b0;
        cnt_nxt_s = '0;
      end else begin
        cnt_nxt_s = cnt_r + 1'b1;
      end
    end else begin
      act_nxt_s = 1'b0;
      cnt_nxt_s = '0;
    end
  end

  // outputs are registered from the next-state values so they line up with the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      cnt_r <= '0;
      addr0 <= '0;
      addr1 <= '0;
      last  <= 1'b0;
      free  <= 1'b1;
    end else begin
      valid <= act_nxt_s;
      cnt_r <= cnt_nxt_s;
      addr0 <= act_nxt_s ? zeta_addr(cnt_nxt_s, 1'b0, STAGE, inv_nxt_s) : '0;
      addr1 <= act_nxt_s ? zeta_addr(cnt_nxt_s, 1'b1, STAGE, inv_nxt_s) : '0;
      last  <= act_nxt_s && (cnt_nxt_s == CNT_LAST);
      free  <= !act_nxt_s || (cnt_nxt_s == CNT_LAST);
    end
  end

endmodule

// File: rtl/ntt_zeta_sched.sv
// Zeta ROM address scheduler: token delay line, per-stage counters, ready and done.
// Optional inverse (mirrored) addressing with ZETA_SCHED_INTT_EN.
module ntt_zeta_sched
  import ntt_pkg::*;
#(
  parameter int STAGE_LAT = 4
) (
  input logic              clk,
  input logic              rst_n,
  ntt_zeta_sched_if.slave  bus
);

  localparam int DLY = (NTT_STAGE_CNT - 1) * STAGE_LAT;

  logic                     tok0_s;
  logic [DLY-1:0]           tok_sr_r;
  logic [NTT_STAGE_CNT-1:0] tok_s;
  logic [NTT_STAGE_CNT-1:0] valid_s;
  logic [NTT_STAGE_CNT-1:0] last_s;
  logic [NTT_STAGE_CNT-1:0] free_s;
  zeta_addr_t               addr0_s [NTT_STAGE_CNT];
  zeta_addr_t               addr1_s [NTT_STAGE_CNT];
  logic                     done_r;
  logic                     unused_s;

  assign tok0_s = bus.start && bus.ready;

  // launch tokens; bit k is the accepted start delayed k+1 cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_sr_r <= '0;
    end else begin
      tok_sr_r <= {tok_sr_r[DLY-2:0], tok0_s};
    end
  end

`ifdef ZETA_SCHED_INTT_EN
  logic [DLY-1:0]           inv_sr_r;
  logic [NTT_STAGE_CNT-1:0] inv_s;

  // inverse flag rides alongside the token line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_sr_r <= '0;
    end else begin
      inv_sr_r <= {inv_sr_r[DLY-2:0], bus.inverse};
    end
  end
`endif

  for (genvar s = 0; s < NTT_STAGE_CNT; s++) begin : g_stage
    if (s == 0) begin : g_first
      assign tok_s[s] = tok0_s;
`ifdef ZETA_SCHED_INTT_EN
      assign inv_s[s] = bus.inverse;
`endif
    end else begin : g_later
      assign tok_s[s] = tok_sr_r[s*STAGE_LAT-1];
`ifdef ZETA_SCHED_INTT_EN
      assign inv_s[s] = inv_sr_r[s*STAGE_LAT-1];
`endif
    end

    zeta_stage_cnt #(.STAGE(s)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .tok   (tok_s[s]),
`ifdef ZETA_SCHED_INTT_EN
      .inv   (inv_s[s]),
`endif
      .valid (valid_s[s]),
      .addr0 (addr0_s[s]),
      .addr1 (addr1_s[s]),
      .last  (last_s[s]),
      .free  (free_s[s])
    );
  end

  // done follows the final stage's last address cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
    end else begin
      done_r <= last_s[NTT_STAGE_CNT-1];
    end
  end

  // gather per-stage address registers onto the lane x stage bus
  always_comb begin
    bus.rom_addr = '0;
    for (int s = 0; s < NTT_STAGE_CNT; s++) begin
      bus.rom_addr[0][s] = addr0_s[s];
      bus.rom_addr[1][s] = addr1_s[s];
    end
  end

  assign bus.stage_valid = valid_s;
  assign bus.ready       = free_s[0];
  assign bus.done        = done_r;
  assign unused_s        = ^{last_s[NTT_STAGE_CNT-2:0], free_s[NTT_STAGE_CNT-1:1]};

endmodule

// File: tb/tb_ntt_zeta_sched.sv
// Scoreboard bench for ntt_zeta_sched: a cycle-level reference model queues expected outputs per stage.
module tb_ntt_zeta_sched;
  import ntt_pkg::*;

  localparam int L = 4;
  localparam int S = NTT_STAGE_CNT;
  localparam int C = ZETA_CYCLES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inv_drv = 1'b0;

  ntt_zeta_sched_if bus();

  ntt_zeta_sched #(.STAGE_LAT(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef ZETA_SCHED_INTT_EN
  assign bus.inverse = inv_drv;
`else
  wire unused_inv = inv_drv;
`endif

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int a0;
    int a1;
  } exp_t;

  exp_t exp_q [S][$];
  int   done_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_until = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // zeta index of butterfly j at stage s, from the twiddle-tree layout
  function automatic int ref_addr(input int s, input int j, input bit inv);
    int a;
    if (s == 0) return 0;
    a = j / (2 ** (S - 1 - s));
    if (inv) a = (2 ** s) - 1 - a;
    return a;
  endfunction

  function automatic bit model_empty();
    bit e;
    e = (done_q.size() == 0);
    for (int s = 0; s < S; s++) if (exp_q[s].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < S; s++) exp_q[s].delete();
    done_q.delete();
    busy_until = 0;
  endtask

  // reference model: decide acceptance and enqueue the whole polynomial's outputs
  always @(posedge clk) begin
    if (rst_n && bus.start && (cyc >= busy_until)) begin
      bit   inv;
      exp_t e;
      inv = 1'b0;
`ifdef ZETA_SCHED_INTT_EN
      inv = bus.inverse;
`endif
      busy_until = cyc + C;
      for (int s = 0; s < S; s++) begin
        for (int c = 0; c < C; c++) begin
          e.cyc = cyc + 1 + s * L + c;
          e.a0  = ref_addr(s, 2 * c, inv);
          e.a1  = ref_addr(s, 2 * c + 1, inv);
          exp_q[s].push_back(e);
        end
      end
      done_q.push_back(cyc + (S - 1) * L + C + 1);
    end
    cyc++;
  end

  // monitor: compare DUT outputs against the queued expectations
  always @(negedge clk) begin
    if (rst_n) begin
      check(bus.ready == (cyc >= busy_until), "ready", int'(bus.ready), int'(cyc >= busy_until));
      for (int s = 0; s < S; s++) begin
        if (bus.stage_valid[s]) begin
          check(exp_q[s].size() != 0, "unexpected_valid", s, -1);
          if (exp_q[s].size() != 0) begin
            exp_t e;
            e = exp_q[s].pop_front();
            check(e.cyc == cyc, "valid_cycle", cyc, e.cyc);
            check(int'(bus.rom_addr[0][s]) == e.a0, "rom_addr_lane0", int'(bus.rom_addr[0][s]), e.a0);
            check(int'(bus.rom_addr[1][s]) == e.a1, "rom_addr_lane1", int'(bus.rom_addr[1][s]), e.a1);
          end
        end else begin
          check(bus.rom_addr[0][s] == '0 && bus.rom_addr[1][s] == '0, "idle_addr",
                int'(bus.rom_addr[0][s]) + int'(bus.rom_addr[1][s]), 0);
          check(!(exp_q[s].size() != 0 && exp_q[s][0].cyc <= cyc), "missing_valid", s, cyc);
        end
      end
      if (bus.done) begin
        check(done_q.size() != 0, "unexpected_done", cyc, -1);
        if (done_q.size() != 0) check(done_q.pop_front() == cyc, "done_cycle", cyc, -1);
      end else begin
        check(!(done_q.size() != 0 && done_q[0] <= cyc), "missing_done", cyc, (done_q.size() != 0) ? done_q[0] : -1);
      end
    end
  end

  task automatic check_reset_vals();
    check(bus.ready == 1'b1, "reset_ready", int'(bus.ready), 1);
    check(bus.stage_valid == '0, "reset_stage_valid", int'(bus.stage_valid), 0);
    check(bus.done == 1'b0, "reset_done", int'(bus.done), 0);
    check(bus.rom_addr == '0, "reset_rom_addr", int'(bus.rom_addr != '0), 0);
  endtask

  task automatic start_pulse(input bit inv);
    bus.start = 1'b1;
    inv_drv   = inv;
    @(negedge clk);
    bus.start = 1'b0;
    inv_drv   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 600; i++) begin
      if (model_empty()) break;
      @(negedge clk);
    end
    check(model_empty(), "drain", int'(model_empty()), 1);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals();
    #1 rst_n = 1'b1;

    // single forward polynomial launched in cycle 10
    while (cyc < 10) @(negedge clk);
    start_pulse(1'b0);
    drain();

    // single inverse polynomial (forward if the option is not built)
    start_pulse(1'b1);
    drain();

    // back-to-back: second start lands on stage 0's last cycle
    bus.start = 1'b1;
    repeat (C + 1) @(negedge clk);
    bus.start = 1'b0;
    drain();

    // start held high while busy, random direction per cycle
    bus.start = 1'b1;
    for (int i = 0; i < 3 * C + 20; i++) begin
      inv_drv = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.start = 1'b0;
    drain();

    // random start/inverse traffic
    for (int i = 0; i < 800; i++) begin
      bus.start = ($urandom_range(0, 7) == 0);
      inv_drv   = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.start = 1'b0;
    drain();

    // reset 50 cycles into a run abandons it
    start_pulse(1'b0);
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    check_reset_vals();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (120) @(negedge clk);
    start_pulse(1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
